// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit.
// Multiplies take one compute cycle. Divides use a restoring algorithm that
// produces one quotient bit per cycle on operand magnitudes.
// Divide-by-zero and signed overflow bypass the divider entirely.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct_3,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [2:0]        op_code;
    logic [XLEN-1:0]   src_a;
    logic [XLEN-1:0]   src_b;
    logic [XLEN-1:0]   part_rem;
    logic [CNT_W-1:0]  step_count;
    logic              neg_quot;
    logic              neg_rem;

    logic              accept;
    logic              in_signed;
    logic              is_div_zero;
    logic              is_overflow;
    logic              is_special;
    logic [XLEN-1:0]   special_result;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              last_step;

    logic [2*XLEN-1:0] ext_a;
    logic [2*XLEN-1:0] ext_b;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   mul_result;

    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_diff;
    logic              quot_bit;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quot_next;
    logic [XLEN-1:0]   div_raw;
    logic [XLEN-1:0]   div_result;

    // Classify the incoming request: operand magnitudes and the two shortcut cases.
    always_comb begin
        accept      = in_valid & in_ready & ~flush;
        in_signed   = funct_3[2] & ~funct_3[0];
        is_div_zero = (in2 == '0);
        is_overflow = in_signed & (in1 == MOST_NEG) & (in2 == '1);
        is_special  = funct_3[2] & (is_div_zero | is_overflow);
        mag_a       = (in_signed & in1[XLEN-1]) ? -in1 : in1;
        mag_b       = (in_signed & in2[XLEN-1]) ? -in2 : in2;
        if (is_div_zero) begin
            special_result = funct_3[1] ? in1 : '1;
        end else begin
            special_result = funct_3[1] ? '0 : in1;
        end
        last_step = (step_count == CNT_W'(XLEN - 1));
    end

    // Full-width product with per-operand sign extension selected by the opcode.
    always_comb begin
        ext_a = {{XLEN{((op_code == 3'd1) | (op_code == 3'd2)) & src_a[XLEN-1]}}, src_a};
        ext_b = {{XLEN{(op_code == 3'd1) & src_b[XLEN-1]}}, src_b};
        product = ext_a * ext_b;
        mul_result = (op_code == 3'd0) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end

    // One restoring-divide step; src_a shifts dividend bits out and quotient bits in.
    always_comb begin
        rem_shift  = {part_rem, src_a[XLEN-1]};
        rem_diff   = rem_shift - {1'b0, src_b};
        quot_bit   = ~rem_diff[XLEN];
        rem_next   = quot_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quot_next  = {src_a[XLEN-2:0], quot_bit};
        div_raw    = op_code[1] ? rem_next : quot_next;
        div_result = (op_code[1] ? neg_rem : neg_quot) ? -div_raw : div_raw;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!funct_3[2]) begin
                        next_state = MUL;
                    end else if (is_special) begin
                        next_state = DONE;
                    end else begin
                        next_state = DIV;
                    end
                end
            end
            MUL:  next_state = DONE;
            DIV:  if (last_step) next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) begin
            next_state = IDLE;
        end
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Operand capture, divider iteration and result register; flush leaves all untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_code    <= '0;
            src_a      <= '0;
            src_b      <= '0;
            part_rem   <= '0;
            step_count <= '0;
            neg_quot   <= 1'b0;
            neg_rem    <= 1'b0;
            out        <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_code    <= funct_3;
                        part_rem   <= '0;
                        step_count <= '0;
                        neg_quot   <= in_signed & (in1[XLEN-1] ^ in2[XLEN-1]);
                        neg_rem    <= in_signed & in1[XLEN-1];
                        if (funct_3[2]) begin
                            src_a <= mag_a;
                            src_b <= mag_b;
                            if (is_special) begin
                                out <= special_result;
                            end
                        end else begin
                            src_a <= in1;
                            src_b <= in2;
                        end
                    end
                end
                MUL: out <= mul_result;
                DIV: begin
                    src_a      <= quot_next;
                    part_rem   <= rem_next;
                    step_count <= step_count + CNT_W'(1);
                    if (last_step) begin
                        out <= div_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven and randomized checks of muldiv_unit with a
// scoreboard queue, plus hand-written handshake, reset and flush sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct_3;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_queue[$];

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
        int          latency;
    } vec_t;

    vec_t vecs[16];

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct_3   (funct_3),
        .in1       (in1),
        .in2       (in2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference behaviour of the RV32M ops, written from the ISA definition.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        int                 sa;
        int                 sb;
        sa = a;
        sb = b;
        model = '0;
        case (f)
            3'd0: begin pu = {32'b0, a} * {32'b0, b}; model = pu[31:0]; end
            3'd1: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); model = ps[63:32]; end
            3'd2: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); model = ps[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; model = pu[63:32]; end
            3'd4: begin
                if (b == 0) model = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = a;
                else model = 32'(sa / sb);
            end
            3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) model = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h0;
                else model = 32'(sa % sb);
            end
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 2;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Present one request at a negedge, push its expected result on the accepting edge,
    // then scramble the inputs so late changes would corrupt a non-latching design.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] result, input bit push);
        int wait_count;
        wait_count = 0;
        @(negedge clk);
        while (!in_ready && wait_count < 50) begin
            @(negedge clk);
            wait_count++;
        end
        checkValue("in_ready before request", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        funct_3  = f;
        in1      = a;
        in2      = b;
        @(posedge clk);
        if (push) exp_queue.push_back(result);
        #1;
        in_valid = 1'b0;
        in1      = $urandom;
        in2      = $urandom;
        funct_3  = 3'($urandom);
        checkValue("busy after accept", 32'(busy), 32'd1);
    endtask

    // Wait (bounded) for out_valid, compare latency and result against the scoreboard,
    // and if out_ready is high verify the handoff back to IDLE.
    task automatic checkOutput(input string name, input int exp_latency);
        int          latency;
        logic [31:0] want;
        latency = 1;
        while (!out_valid && latency < 40) begin
            @(posedge clk);
            #1;
            latency++;
        end
        want = (exp_queue.size() > 0) ? exp_queue.pop_front() : 32'hDEAD_BEEF;
        checkValue({name, " out_valid"}, 32'(out_valid), 32'd1);
        checkValue({name, " latency"}, 32'(latency), 32'(exp_latency));
        checkValue({name, " out"}, out, want);
        if (out_ready) begin
            @(posedge clk);
            #1;
            checkValue({name, " handoff busy/valid/ready"}, 32'({busy, out_valid, in_ready}), 32'b001);
            checkValue({name, " out retained"}, out, want);
        end
    endtask

    // Main test sequence.
    initial begin
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        funct_3   = 3'd0;
        in1       = '0;
        in2       = '0;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
        vecs[11] = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
        vecs[12] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[13] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};
        vecs[14] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
        vecs[15] = '{3'd3, 32'h8000_0000, 32'd4,         32'd2,         2};

        #1;
        checkValue("reset out", out, 32'd0);
        checkValue("reset out_valid", 32'(out_valid), 32'd0);
        checkValue("reset busy", 32'(busy), 32'd0);
        checkValue("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].result, 1'b1);
            checkOutput($sformatf("vec%0d", i), vecs[i].latency);
        end

        for (int i = 0; i < 12; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 4 == 3) ? 32'd0 : (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            applyStimulus(rf, ra, rb, model(rf, ra, rb), 1'b1);
            checkOutput($sformatf("rand%0d f=%0d", i, rf), model_latency(rf, ra, rb));
        end

        $display("[TB] holding result with out_ready low");
        out_ready = 1'b0;
        applyStimulus(3'd0, 32'd6, 32'd7, 32'd42, 1'b1);
        checkOutput("hold MUL", 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkValue($sformatf("hold%0d out_valid", i), 32'(out_valid), 32'd1);
            checkValue($sformatf("hold%0d out", i), out, 32'd42);
            checkValue($sformatf("hold%0d in_ready", i), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        funct_3   = 3'd5;
        in1       = 32'd100;
        in2       = 32'd7;
        @(posedge clk);
        #1;
        checkValue("no accept on handoff busy", 32'(busy), 32'd0);
        checkValue("no accept on handoff out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        exp_queue.push_back(32'd14);
        #1;
        in_valid = 1'b0;
        checkValue("accept after idle cycle", 32'(busy), 32'd1);
        checkOutput("after hold DIVU", 33);

        $display("[TB] async reset during divide");
        applyStimulus(3'd5, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkValue("mid-div reset out", out, 32'd0);
        checkValue("mid-div reset out_valid", 32'(out_valid), 32'd0);
        checkValue("mid-div reset busy", 32'(busy), 32'd0);
        checkValue("mid-div reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] flush during divide");
        applyStimulus(3'd5, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        checkValue("flush busy", 32'(busy), 32'd0);
        checkValue("flush out_valid", 32'(out_valid), 32'd0);
        checkValue("flush out unchanged", out, 32'd0);
        @(negedge clk);
        in_valid = 1'b1;
        funct_3  = 3'd0;
        in1      = 32'd3;
        in2      = 32'd3;
        @(posedge clk);
        #1;
        checkValue("flush blocks accept", 32'(busy), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        applyStimulus(3'd5, 32'd100, 32'd7, 32'd14, 1'b1);
        checkOutput("post flush DIVU", 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, giving the operand and result width in bits (even, >= 8).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: request present.
REQ-005 The module SHALL have port in_ready, output, 1 bit: unit can accept a request.
REQ-006 The module SHALL have port funct_3, input, 3 bits: RV32M op (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-007 The module SHALL have port in1, input, XLEN bits: rs1 operand.
REQ-008 The module SHALL have port in2, input, XLEN bits: rs2 operand.
REQ-009 The module SHALL have port flush, input, 1 bit: abort any in-flight operation.
REQ-010 The module SHALL have port out_valid, output, 1 bit: result is available.
REQ-011 The module SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 The module SHALL have port out, output, XLEN bits: result for rd.
REQ-013 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, MUL, DIV, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a request SHALL be accepted on an edge where in_valid=1, in_ready=1 and flush=0.
REQ-016 On acceptance, funct_3, in1 and in2 SHALL be latched; later input changes SHALL NOT affect the result.
REQ-017 On accepting funct_3 0-3, the FSM SHALL go IDLE->MUL; MUL SHALL compute the 2*XLEN-bit product and go to DONE on the next edge (out_valid 2 edges after acceptance).
REQ-018 Product extraction: MUL SHALL give the low XLEN bits; MULH the high XLEN bits of signed*signed; MULHSU the high XLEN bits of signed*unsigned; MULHU the high XLEN bits of unsigned*unsigned.
REQ-019 On accepting funct_3 4-7 with in2 != 0 and not signed overflow, the FSM SHALL go IDLE->DIV and run a restoring divide, one quotient bit per cycle, on operand magnitudes.
REQ-020 DIV SHALL last exactly XLEN cycles, then go to DONE with sign correction applied (out_valid XLEN+1 edges after acceptance).
REQ-021 Signed division SHALL truncate toward zero; quotient sign = sign(in1) XOR sign(in2); remainder sign = sign(in1).
REQ-022 For division by zero, the FSM SHALL go directly IDLE->DONE: DIV/DIVU out = all ones; REM/REMU out = in1.
REQ-023 For signed overflow (in1 = most negative, in2 = -1, DIV/REM), the FSM SHALL go directly IDLE->DONE: DIV out = in1; REM out = 0.
REQ-024 In DONE, out_valid SHALL be 1 and out SHALL hold stable until the edge where out_ready=1, after which the FSM SHALL return to IDLE.
REQ-025 out_valid SHALL be 0 in all states except DONE; out SHALL retain its last value when out_valid=0.
REQ-026 flush=1 SHALL force the FSM to IDLE on the next edge from any state, discard the operation and block acceptance on that edge; out SHALL be unchanged.
REQ-027 A new request SHALL NOT be accepted on the same edge that DONE hands off; minimum spacing between acceptances SHALL be one IDLE cycle.

Reset
REQ-028 reset=1 SHALL immediately, without waiting for a clock edge, force IDLE, out=0, out_valid=0, busy=0 and in_ready=1, including mid-division.
REQ-029 After reset deasserts, the first request SHALL be accepted on the first qualifying edge.

Verification
REQ-030 MUL: in1=7, in2=-3 (0xFFFFFFFD), funct_3=0 -> out=0xFFFFFFEB, out_valid 2 edges after acceptance.
REQ-031 MULH/MULHU/MULHSU with in1=in2=0xFFFFFFFF -> 0x00000000 / 0xFFFFFFFE / 0xFFFFFFFF.
REQ-032 DIV in1=-7, in2=2 -> out=0xFFFFFFFD after 33 edges; REM same operands -> 0xFFFFFFFF.
REQ-033 DIVU in1=5, in2=0 -> 0xFFFFFFFF in 1 edge; DIV in1=0x80000000, in2=-1 -> 0x80000000; REM same -> 0.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> out and out_valid stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-035 Assert reset at iteration 10 of DIVU, then flush at iteration 5 of a second DIVU -> both return to IDLE with out_valid=0; the next request (DIVU 100/7) yields 14.
